// File: rtl/midi_uart_rx.sv
// midi_uart_rx: 8-N-1 serial receiver for the MIDI IN line (idle high, LSB first)
//   clk       in      system clock, rising edge
//   rst_n     in      asynchronous active-low reset
//   rx_in     in      raw serial line, asynchronous to clk
//   dout      out [8] last correctly framed byte
//   dout_rdy  out     one-cycle pulse, dout updated this cycle
//   frame_err out     one-cycle pulse, stop bit sampled low and byte dropped
//   busy      out     high while a frame is being received
module midi_uart_rx #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 31250
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_in,
  output logic [7:0] dout,
  output logic       dout_rdy,
  output logic       frame_err,
  output logic       busy
);
  localparam int CPB  = CLK_FREQ / BAUD;
  localparam int HALF = CPB / 2;
  localparam int CW   = $clog2(CPB);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t          state_q, state_d;
  logic [1:0]      sync_q;
  logic            rx_p_q;
  logic            rx_s;
  logic            tick;
  logic [CW-1:0]   clk_cnt_q, clk_cnt_d;
  logic [3:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      dout_q, dout_d;
  logic            dout_rdy_q, dout_rdy_d;
  logic            frame_err_q, frame_err_d;
  assign rx_s = sync_q[1];
  // START waits half a bit to land mid start bit; later states sample once per bit
  assign tick = (state_q == START) ? (clk_cnt_q == CW'(HALF - 1)) : (clk_cnt_q == CW'(CPB - 1));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q      <= '0;
      rx_p_q      <= 1'b0;
      state_q     <= IDLE;
      clk_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      dout_q      <= '0;
      dout_rdy_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      sync_q      <= {sync_q[0], rx_in};
      rx_p_q      <= sync_q[1];
      state_q     <= state_d;
      clk_cnt_q   <= clk_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      dout_q      <= dout_d;
      dout_rdy_q  <= dout_rdy_d;
      frame_err_q <= frame_err_d;
    end
  end
  // Synchronizer flops reset low, so only a genuine high-to-low edge starts a frame
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  state_d = (!rx_s && rx_p_q) ? START : IDLE;
      START: state_d = tick ? (rx_s ? IDLE : DATA) : START;
      DATA:  state_d = (tick && bit_cnt_q == 4'd7) ? STOP : DATA;
      STOP:  state_d = tick ? IDLE : STOP;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    clk_cnt_d   = (state_q == IDLE || tick) ? '0 : clk_cnt_q + 1'b1;
    bit_cnt_d   = (state_q == IDLE) ? 4'd0 : (state_q == DATA && tick) ? bit_cnt_q + 4'd1 : bit_cnt_q;
    shift_d     = (state_q == DATA && tick) ? {rx_s, shift_q[7:1]} : shift_q;
    dout_rdy_d  = (state_q == STOP) && tick && rx_s;
    frame_err_d = (state_q == STOP) && tick && !rx_s;
    dout_d      = dout_rdy_d ? shift_q : dout_q;
    busy        = (state_q != IDLE);
    dout        = dout_q;
    dout_rdy    = dout_rdy_q;
    frame_err   = frame_err_q;
  end
endmodule
